// File: rtl/shift_pkg.sv
// Shared definitions for the shift sequencer: mode encodings, FSM states and pass limits.
package shift_pkg;

  localparam logic [2:0] MODE_ROL = 3'b100;
  localparam logic [2:0] MODE_ROR = 3'b101;
  localparam logic [2:0] MODE_LSH = 3'b000;
  localparam logic [2:0] MODE_SHR = 3'b001;
  localparam logic [2:0] MODE_SAR = 3'b011;

  localparam int unsigned MAX_STEP = 15;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // Any mode with bit 2 set is a rotate (1x0 left, 1x1 right).
  function automatic logic is_rotate(input logic [2:0] mode);
    return mode[2];
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; last grant pointer moves only on an accepted grant.
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic valid0,
  input  logic valid1,
  input  logic accept,
  output logic gnt_valid,
  output logic gnt_id
);

  logic last_q;

  always_comb begin
    gnt_valid = valid0 | valid1;
    if (valid0 && valid1) begin
      gnt_id = ~last_q;
    end else begin
      gnt_id = valid1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (accept && gnt_valid) begin
      last_q <= gnt_id;
    end
  end

endmodule

// File: rtl/univ_shifter.sv
// Combinational 16-bit shifter: rotates, logical shifts and arithmetic right, amount 0-15.
module univ_shifter (
  input  logic [15:0] data,
  input  logic [3:0]  amt,
  input  logic [2:0]  mode,
  output logic [15:0] result
);

  logic [31:0] dbl;

  always_comb begin
    dbl    = {data, data};
    result = data;
    if (mode[2]) begin
      // Shifting the doubled word yields the rotate in one half.
      if (mode[0]) begin
        dbl    = {data, data} >> amt;
        result = dbl[15:0];
      end else begin
        dbl    = {data, data} << amt;
        result = dbl[31:16];
      end
    end else begin
      unique case (mode[1:0])
        2'b00, 2'b10: result = data << amt;
        2'b01:        result = data >> amt;
        2'b11:        result = $signed(data) >>> amt;
        default:      result = data;
      endcase
    end
  end

endmodule

// File: rtl/shift_sched.sv
// Two-client shift sequencer: arbitrates requests and runs the 0-15 shifter over multiple passes
// to support amounts up to 31.
module shift_sched
  import shift_pkg::*;
#(
  parameter int unsigned AMT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [15:0]      req0_data,
  input  logic [AMT_W-1:0] req0_amt,
  input  logic [2:0]       req0_mode,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [15:0]      req1_data,
  input  logic [AMT_W-1:0] req1_amt,
  input  logic [2:0]       req1_mode,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [15:0]      rsp_data,
  output logic             rsp_id
);

  state_e           state_q, state_d;
  logic [15:0]      acc_q, acc_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [2:0]       mode_q, mode_d;
  logic             id_q, id_d;

  logic             accept, gnt_valid, gnt_id, handshake;
  logic [3:0]       step;
  logic [15:0]      shift_out;
  logic [15:0]      sel_data;
  logic [AMT_W-1:0] sel_amt;
  logic [2:0]       sel_mode;

  assign accept     = (state_q == StIdle) && !rst;
  assign handshake  = accept && gnt_valid;
  assign req0_ready = handshake && !gnt_id;
  assign req1_ready = handshake && gnt_id;

  assign sel_data = gnt_id ? req1_data : req0_data;
  assign sel_amt  = gnt_id ? req1_amt  : req0_amt;
  assign sel_mode = gnt_id ? req1_mode : req0_mode;

  assign step = (rem_q > AMT_W'(MAX_STEP)) ? 4'(MAX_STEP) : rem_q[3:0];

  rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .valid0    (req0_valid),
    .valid1    (req1_valid),
    .accept    (accept),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  univ_shifter u_shifter (
    .data   (acc_q),
    .amt    (step),
    .mode   (mode_q),
    .result (shift_out)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    mode_d  = mode_q;
    id_d    = id_q;
    unique case (state_q)
      StIdle: begin
        if (handshake) begin
          acc_d   = sel_data;
          mode_d  = sel_mode;
          id_d    = gnt_id;
          // Rotates wrap at 16, so a single pass always suffices.
          rem_d   = is_rotate(sel_mode) ? AMT_W'(sel_amt[3:0]) : sel_amt;
          state_d = StRun;
        end
      end
      StRun: begin
        acc_d = shift_out;
        rem_d = rem_q - AMT_W'(step);
        if (is_rotate(mode_q) || rem_d == '0) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      rem_q   <= '0;
      mode_q  <= '0;
      id_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
      id_q    <= id_d;
    end
  end

  assign rsp_valid = (state_q == StDone);
  assign rsp_data  = acc_q;
  assign rsp_id    = id_q;

endmodule

// File: tb/tb_shift_sched.sv
// Directed and randomized bench for shift_sched against an arithmetic reference model.
module tb_shift_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [15:0] req0_data, req1_data;
  logic [4:0]  req0_amt, req1_amt;
  logic [2:0]  req0_mode, req1_mode;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [15:0] rsp_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_sched #(.AMT_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_data  (req0_data),
    .req0_amt   (req0_amt),
    .req0_mode  (req0_mode),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_data  (req1_data),
    .req1_amt   (req1_amt),
    .req1_mode  (req1_mode),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: whole-amount shift semantics computed directly.
  function automatic logic [15:0] model_result(input logic [15:0] d, input int a,
                                               input logic [2:0] m);
    logic [31:0] x;
    int r;
    x = {16'h0, d};
    if (m[2]) begin
      r = a % 16;
      if (r == 0) return d;
      if (!m[0]) x = (x << r) | (x >> (16 - r));
      else       x = (x >> r) | (x << (16 - r));
      return x[15:0];
    end
    if (m[1:0] == 2'b01) return (a >= 16) ? 16'h0 : 16'(x >> a);
    if (m[1:0] == 2'b11) begin
      if (a >= 16) return d[15] ? 16'hFFFF : 16'h0;
      x = x >> a;
      if (d[15]) x = x | (32'hFFFF << (16 - a));
      return x[15:0];
    end
    return (a >= 16) ? 16'h0 : 16'(x << a);
  endfunction

  function automatic int model_passes(input int a, input logic [2:0] m);
    if (m[2] || a == 0) return 1;
    return (a + 14) / 15;
  endfunction

  task automatic drive_req(input bit id, input logic [15:0] d, input logic [4:0] a,
                           input logic [2:0] m);
    if (id) begin
      req1_valid = 1'b1; req1_data = d; req1_amt = a; req1_mode = m;
    end else begin
      req0_valid = 1'b1; req0_data = d; req0_amt = a; req0_mode = m;
    end
  endtask

  // One request through to response, with optional backpressure in DONE.
  task automatic run_op(input string tag, input bit id, input logic [15:0] d,
                        input logic [4:0] a, input logic [2:0] m, input int hold);
    int cyc;
    logic [15:0] exp_d;
    exp_d = model_result(d, int'(a), m);
    @(negedge clk);
    drive_req(id, d, a, m);
    #1;
    cyc = 0;
    while (!(id ? req1_ready : req0_ready) && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_grant"}, {31'd0, id ? req1_ready : req0_ready}, 32'd1);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    cyc = 1;
    while (!rsp_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_lat"}, cyc, model_passes(int'(a), m) + 1);
    check({tag, "_data"}, {16'd0, rsp_data}, {16'd0, exp_d});
    check({tag, "_id"}, {31'd0, rsp_id}, {31'd0, id});
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold"}, {13'd0, rsp_valid, req0_ready, req1_ready, rsp_id, rsp_data},
            {13'd0, 1'b1, 1'b0, 1'b0, id, exp_d});
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, "_rsp_drop"}, {31'd0, rsp_valid}, 32'd0);
    req0_valid = 1'b1;
    #1;
    check({tag, "_reaccept"}, {31'd0, req0_ready}, 32'd1);
    req0_valid = 1'b0;
    #1;
  endtask

  initial begin
    logic [16:0] expq[$];
    logic [16:0] e;
    int grants, rsps, pend, cyc, seen;
    logic [15:0] rd;
    logic [4:0] ra;
    logic [2:0] rm;

    // Reset with both requesters already valid.
    rst = 1'b1;
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_data = 16'h1111; req0_amt = 5'd3;  req0_mode = 3'b000;
    req1_valid = 1'b1; req1_data = 16'h8222; req1_amt = 5'd17; req1_mode = 3'b011;
    repeat (2) @(negedge clk);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_data", {16'd0, rsp_data}, 32'd0);
    check("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
    check("rst_readies", {30'd0, req0_ready, req1_ready}, 32'd0);

    // Continuous contention: grants alternate, responses in order, nothing lost.
    rst = 1'b0;
    rsp_ready = 1'b1;
    grants = 0; rsps = 0; pend = -1;
    for (int c = 0; c < 300 && (grants < 8 || rsps < 8); c++) begin
      if (pend == 0) begin
        req0_data = 16'($urandom); req0_amt = 5'($urandom); req0_mode = 3'($urandom);
      end else if (pend == 1) begin
        req1_data = 16'($urandom); req1_amt = 5'($urandom); req1_mode = 3'($urandom);
      end
      pend = -1;
      if (grants >= 8) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      #1;
      if (req0_ready || req1_ready) begin
        check("arb_order", {31'd0, req1_ready}, 32'(grants % 2));
        if (req1_ready) expq.push_back({1'b1, model_result(req1_data, int'(req1_amt), req1_mode)});
        else            expq.push_back({1'b0, model_result(req0_data, int'(req0_amt), req0_mode)});
        pend = req1_ready ? 1 : 0;
        grants++;
      end
      if (rsp_valid) begin
        if (expq.size() == 0) begin
          check("arb_extra_rsp", 32'd1, 32'd0);
        end else begin
          e = expq.pop_front();
          check("arb_rsp", {15'd0, rsp_id, rsp_data}, {15'd0, e});
        end
        rsps++;
      end
      @(negedge clk);
    end
    check("arb_counts", {grants[15:0], rsps[15:0]}, {16'd8, 16'd8});
    rsp_ready = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);

    // Directed operations.
    run_op("ror1", 1'b0, 16'h8001, 5'd1, 3'b101, 0);
    run_op("rol4", 1'b0, 16'h1234, 5'd4, 3'b100, 0);
    run_op("rol16", 1'b1, 16'h1234, 5'd16, 3'b110, 0);
    run_op("sar20", 1'b1, 16'h8000, 5'd20, 3'b011, 0);
    run_op("lsh31", 1'b0, 16'h0001, 5'd31, 3'b000, 0);
    run_op("shr15", 1'b0, 16'hFFFF, 5'd15, 3'b001, 0);
    run_op("amt0", 1'b1, 16'hA5C3, 5'd0, 3'b011, 0);
    run_op("bp5", 1'b1, 16'h0F0F, 5'd7, 3'b010, 5);

    // Randomized operations.
    for (int n = 0; n < 40; n++) begin
      run_op("rand", 1'($urandom), 16'($urandom), 5'($urandom), 3'($urandom),
             int'($urandom_range(0, 2)));
    end

    // Reset in the middle of a 3-pass op.
    @(negedge clk);
    drive_req(1'b0, 16'h0001, 5'd31, 3'b000);
    #1;
    check("mid_grant", {31'd0, req0_ready}, 32'd1);
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    @(negedge clk);
    check("mid_rst_rsp", {31'd0, rsp_valid}, 32'd0);
    check("mid_rst_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_grant", {30'd0, req0_ready, req1_ready}, 32'd2);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    seen = 0;
    for (cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("mid_no_rsp", seen, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
